// File: rtl/rect_pattern_gen_pkg.sv
// Shared mode encoding and default geometry for the raster pattern generator.
// Defaults describe the 400x225 display frame store.
package pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_BLANK   = 2'd0,
    MODE_DIAG    = 2'd1,
    MODE_FILL    = 2'd2,
    MODE_OUTLINE = 2'd3
  } mode_e;

  localparam int DEF_H_ACTIVE = 400;
  localparam int DEF_V_ACTIVE = 225;
  localparam int DEF_COLOR_W  = 6;
  localparam int DEF_RECT_W   = 50;
  localparam int DEF_RECT_H   = 50;
  localparam int DEF_X0       = 200;
  localparam int DEF_Y0       = 100;
  localparam int DEF_STEP     = 1;

endpackage

// File: rtl/rect_pattern_gen_scan_counter.sv
// Raster scan position counter: x runs fastest, wraps into y, y wraps at frame end.
// Flags mark the first and last pixel of the frame at the current count.
module scan_counter #(
  parameter int H_ACTIVE = 400,
  parameter int V_ACTIVE = 225,
  parameter int XW       = $clog2(H_ACTIVE),
  parameter int YW       = $clog2(V_ACTIVE)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_advance,
  output logic [XW-1:0] o_x_cnt,
  output logic [YW-1:0] o_y_cnt,
  output logic          o_first,
  output logic          o_last
);

  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_advance) begin
      if (r_x == X_LAST) begin
        r_x <= '0;
        r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign o_x_cnt = r_x;
  assign o_y_cnt = r_y;
  assign o_first = (r_x == '0) && (r_y == '0);
  assign o_last  = (r_x == X_LAST) && (r_y == Y_LAST);

endmodule

// File: rtl/rect_pattern_gen.sv
// Raster pattern generator: walks every pixel of the frame and emits coordinates
// and colour (blank, diagonal, filled or outlined movable rectangle).
module rect_pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int COLOR_W  = DEF_COLOR_W,
  parameter int RECT_W   = DEF_RECT_W,
  parameter int RECT_H   = DEF_RECT_H,
  parameter int X0       = DEF_X0,
  parameter int Y0       = DEF_Y0,
  parameter int STEP     = DEF_STEP,
  parameter int XW       = $clog2(H_ACTIVE),
  parameter int YW       = $clog2(V_ACTIVE)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_buffon_up,
  input  logic               i_buffon_down,
  input  logic               i_buffon_left,
  input  logic               i_buffon_right,
  input  logic [1:0]         i_mode,
  input  logic [COLOR_W-1:0] i_color,
  input  logic               i_ready,
  output logic [XW-1:0]      o_x,
  output logic [YW-1:0]      o_y,
  output logic [COLOR_W-1:0] o_data,
  output logic               o_valid,
  output logic               o_sof,
  output logic               o_done
);

  localparam int X_MAX = H_ACTIVE - RECT_W;
  localparam int Y_MAX = V_ACTIVE - RECT_H;

  // Handshake: o_valid/o_x/o_y/o_data/o_sof form one pixel that transfers on a
  // rising edge with o_valid && i_ready; the register reloads whenever it is
  // empty or being drained, and holds every output while o_valid && !i_ready.
  logic w_load;
  logic w_xfer;
  logic w_last_xfer;

  logic [XW-1:0] w_x_cnt;
  logic [YW-1:0] w_y_cnt;
  logic          w_first;
  logic          w_last;

  logic               r_last;
  mode_e              r_mode;
  mode_e              w_mode;
  logic [COLOR_W-1:0] r_color;
  logic [COLOR_W-1:0] w_color;

  logic [XW-1:0] r_x_min;
  logic [YW-1:0] r_y_min;
  logic [XW-1:0] w_x_min_next;
  logic [YW-1:0] w_y_min_next;
  logic [XW:0]   w_x_dec;
  logic [XW:0]   w_x_inc;
  logic [YW:0]   w_y_dec;
  logic [YW:0]   w_y_inc;

  logic [XW:0] w_xe;
  logic [XW:0] w_xl;
  logic [XW:0] w_xr;
  logic [YW:0] w_ye;
  logic [YW:0] w_yt;
  logic [YW:0] w_yb;
  logic        w_in_rect;
  logic        w_on_edge;
  logic        w_hit;

  assign w_load      = !o_valid || i_ready;
  assign w_xfer      = o_valid && i_ready;
  assign w_last_xfer = w_xfer && r_last;

  scan_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .XW       (XW),
    .YW       (YW)
  ) u_scan (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_advance (w_load),
    .o_x_cnt   (w_x_cnt),
    .o_y_cnt   (w_y_cnt),
    .o_first   (w_first),
    .o_last    (w_last)
  );

  // One extra bit so a decrement below zero shows up as the top bit set.
  assign w_x_dec = {1'b0, r_x_min} - (XW+1)'(STEP);
  assign w_x_inc = {1'b0, r_x_min} + (XW+1)'(STEP);
  assign w_y_dec = {1'b0, r_y_min} - (YW+1)'(STEP);
  assign w_y_inc = {1'b0, r_y_min} + (YW+1)'(STEP);

  always_comb begin
    w_x_min_next = r_x_min;
    w_y_min_next = r_y_min;
    if (w_last_xfer && i_buffon_left && !i_buffon_right)
      w_x_min_next = w_x_dec[XW] ? '0 : w_x_dec[XW-1:0];
    else if (w_last_xfer && i_buffon_right && !i_buffon_left)
      w_x_min_next = (w_x_inc > (XW+1)'(X_MAX)) ? XW'(X_MAX) : w_x_inc[XW-1:0];
    if (w_last_xfer && i_buffon_up && !i_buffon_down)
      w_y_min_next = w_y_dec[YW] ? '0 : w_y_dec[YW-1:0];
    else if (w_last_xfer && i_buffon_down && !i_buffon_up)
      w_y_min_next = (w_y_inc > (YW+1)'(Y_MAX)) ? YW'(Y_MAX) : w_y_inc[YW-1:0];
  end

  // The last-pixel transfer coincides with the load of (0,0), so the new
  // frame is drawn with the freshly moved position: no tearing.
  assign w_mode  = w_first ? mode_e'(i_mode) : r_mode;
  assign w_color = w_first ? i_color : r_color;

  assign w_xe = {1'b0, w_x_cnt};
  assign w_xl = {1'b0, w_x_min_next};
  assign w_xr = w_xl + (XW+1)'(RECT_W - 1);
  assign w_ye = {1'b0, w_y_cnt};
  assign w_yt = {1'b0, w_y_min_next};
  assign w_yb = w_yt + (YW+1)'(RECT_H - 1);

  assign w_in_rect = (w_xe >= w_xl) && (w_xe <= w_xr) && (w_ye >= w_yt) && (w_ye <= w_yb);
  assign w_on_edge = (w_xe == w_xl) || (w_xe == w_xr) || (w_ye == w_yt) || (w_ye == w_yb);

  always_comb begin
    w_hit = 1'b0;
    unique case (w_mode)
      MODE_BLANK:   w_hit = 1'b0;
      MODE_DIAG:    w_hit = (32'(w_x_cnt) == 32'(w_y_cnt));
      MODE_FILL:    w_hit = w_in_rect;
      MODE_OUTLINE: w_hit = w_in_rect && w_on_edge;
      default:      w_hit = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_x     <= '0;
      o_y     <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
      o_done  <= 1'b0;
      r_last  <= 1'b0;
      r_mode  <= MODE_BLANK;
      r_color <= '0;
      r_x_min <= XW'(X0);
      r_y_min <= YW'(Y0);
    end else begin
      if (w_load) begin
        o_x     <= w_x_cnt;
        o_y     <= w_y_cnt;
        o_data  <= w_hit ? w_color : '0;
        o_valid <= 1'b1;
        o_sof   <= w_first;
        r_last  <= w_last;
        if (w_first) begin
          r_mode  <= mode_e'(i_mode);
          r_color <= i_color;
        end
      end
      r_x_min <= w_x_min_next;
      r_y_min <= w_y_min_next;
      if (w_last_xfer)
        o_done <= 1'b1;
    end
  end

endmodule
